// File: rtl/ysyx_22041461_wb_arb.sv
// Write-back arbiter and load scoreboard for the 32x64 GPR file.
// EXU and LSU share the single register-file write port under a 1-bit
// round-robin pointer. A busy bit per register tracks outstanding loads
// for decode hazard stalls.
// Optional feature macro: YSYX_22041461_WB_BYPASS_EN (forwards the
// registered write-back data to decode; otherwise byp_* are tied to 0).
module ysyx_22041461_wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  input  logic [4:0]  exu_rd,
  input  logic [63:0] exu_data,
  output logic        exu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  output logic        lsu_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  input  logic        sb_set,
  input  logic [4:0]  sb_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        sb_err,
  output logic        byp_rs1_hit,
  output logic        byp_rs2_hit,
  output logic [63:0] byp_rs1_data,
  output logic [63:0] byp_rs2_data
);

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  gnt_e        r_last;
  logic        r_wen;
  logic [4:0]  r_rd;
  logic [63:0] r_data;
  logic [31:0] r_busy;
  logic        r_err;

  logic        w_gnt_exu;
  logic        w_gnt_lsu;
  logic [4:0]  w_sel_rd;
  logic [63:0] w_sel_data;
  logic [31:0] w_busy_nxt;
  logic        w_err_hit;

  // Round-robin grant; readies are forced low while reset is asserted.
  always_comb begin
    w_gnt_lsu = rst & lsu_valid & (~exu_valid | (r_last == GNT_EXU));
    w_gnt_exu = rst & exu_valid & ~w_gnt_lsu;
    w_sel_rd   = w_gnt_lsu ? lsu_rd   : exu_rd;
    w_sel_data = w_gnt_lsu ? lsu_data : exu_data;
  end

  assign exu_ready = w_gnt_exu;
  assign lsu_ready = w_gnt_lsu;

  // Grant pointer and registered write port; rd=0 grants write nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= GNT_EXU;
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      if (w_gnt_lsu)      r_last <= GNT_LSU;
      else if (w_gnt_exu) r_last <= GNT_EXU;
      if ((w_gnt_lsu | w_gnt_exu) && (w_sel_rd != 5'd0)) begin
        r_wen  <= 1'b1;
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
      end else begin
        r_wen  <= 1'b0;
      end
    end
  end

  // Scoreboard next state: LSU clear applied first so a same-index set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_lsu) w_busy_nxt[lsu_rd] = 1'b0;
    if (sb_set && (sb_rd != 5'd0)) w_busy_nxt[sb_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_err_hit = sb_set && (sb_rd != 5'd0) && r_busy[sb_rd];
  end

  // Busy bits and sticky double-issue error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  assign wb_wen   = r_wen;
  assign wb_rd    = r_rd;
  assign wb_data  = r_data;
  assign sb_err   = r_err;
  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];

`ifdef YSYX_22041461_WB_BYPASS_EN
  assign byp_rs1_hit  = r_wen && (r_rd == rs1) && (rs1 != 5'd0);
  assign byp_rs2_hit  = r_wen && (r_rd == rs2) && (rs2 != 5'd0);
  assign byp_rs1_data = r_data;
  assign byp_rs2_data = r_data;
`else
  assign byp_rs1_hit  = 1'b0;
  assign byp_rs2_hit  = 1'b0;
  assign byp_rs1_data = '0;
  assign byp_rs2_data = '0;
`endif

endmodule

// File: doc/ysyx_22041461_wb_arb.md
# ysyx_22041461_wb_arb

Write-back arbiter and scoreboard for the 32×64-bit general-purpose register file. It shares the register file's single write port between the execute unit (EXU: ALU/pc/snpc/imm results) and the load/store unit (LSU: load data) with round-robin arbitration. It also tracks registers with an outstanding load so decode can stall on read-after-write hazards. It sits between EXU/LSU and the register file write inputs.

## Interface
- No parameters; data width is 64, register index width is 5.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- exu_valid  in  1  EXU write request
- exu_rd  in  5  EXU destination register
- exu_data  in  64  EXU write data
- exu_ready  out  1  EXU request accepted this cycle
- lsu_valid  in  1  LSU load-return write request
- lsu_rd  in  5  LSU destination register
- lsu_data  in  64  LSU write data
- lsu_ready  out  1  LSU request accepted this cycle
- wb_wen  out  1  register file write enable (registered)
- wb_rd  out  5  register file write index (registered)
- wb_data  out  64  register file write data (registered)
- sb_set  in  1  a load targeting sb_rd is issued
- sb_rd  in  5  destination of the issued load
- rs1, rs2  in  5 each  decode source indices
- rs1_busy, rs2_busy  out  1 each  source has a pending load (combinational)
- sb_err  out  1  sticky: sb_set hit a register that was already busy
- byp_rs1_hit, byp_rs2_hit  out  1 each  bypass hit (only with the macro)
- byp_rs1_data, byp_rs2_data  out  64 each  bypass data (only with the macro)

## Operation
- Handshake: a request transfers when valid && ready in the same cycle. valid must hold with stable rd/data until ready. ready depends combinationally on both valids and on the pointer.
- Arbitration: at most one grant per cycle. With a single valid, that requester is granted. With both valid, the grant goes to the requester not granted last. The 1-bit pointer `last` records the most recent grant; it resets to EXU, so LSU wins the first tie.
- Granted request with rd≠0: the next edge loads wb_wen=1, wb_rd=rd, wb_data=data.
- Granted request with rd=0: accepted (ready=1, pointer updates), but wb_wen=0 on the next edge.
- No grant: the next edge loads wb_wen=0. wb_rd and wb_data hold their previous values.
- Scoreboard: busy[31:0], with bit 0 hardwired to 0.
  - sb_set with sb_rd≠0 sets busy[sb_rd].
  - An LSU grant clears busy[lsu_rd].
  - If both target the same index in the same cycle, set wins.
  - sb_set on an already-busy index keeps it set and sets sb_err. sb_err clears only on reset.
- rsN_busy = busy[rsN]; rsN_busy is 0 when rsN=0.

## Timing
- Reset (asynchronous assert, synchronous-edge release): wb_wen=0, wb_rd=0, wb_data=0, busy=0, sb_err=0, last=EXU. During reset, exu_ready=lsu_ready=0.
- Latency: handshake at edge N → wb_* valid after edge N → register file commits at edge N+1 → readable after N+1.
- Throughput: one write per cycle. Two contending requesters each receive every other cycle.
- A busy bit clears on the edge following the LSU handshake, so rsN_busy drops one cycle before the register file holds the data. This is safe only with the bypass enabled; without it, decode also stalls while wb_wen && wb_rd==rsN.
- Reset mid-operation: in-flight wb_* is dropped and pending busy bits are lost. The LSU must also be reset.

## Configuration
- YSYX_22041461_WB_BYPASS_EN defined:
  - byp_rsN_hit = wb_wen && wb_rd==rsN && rsN≠0.
  - byp_rsN_data = wb_data.
  - Decode muxes the bypass data over the register file read data.
- Undefined: byp_* ports still exist and are tied to 0; no comparators are built.

## Test plan
- Reset release, no requests → all outputs 0; wb_wen stays 0 for 10 cycles.
- exu_valid, rd=5, data=0x1234 alone → exu_ready=1 that cycle; next cycle wb_wen=1, wb_rd=5, wb_data=0x1234; following cycle wb_wen=0.
- Both valid for 4 cycles (EXU rd=1, LSU rd=2) → grants LSU, EXU, LSU, EXU; wb_rd sequence 2,1,2,1.
- lsu_valid with rd=0 → lsu_ready=1 and wb_wen stays 0; a following tie grants EXU.
- sb_set rd=7 → rs1=7 gives rs1_busy=1; LSU handshake on rd=7 → busy clears next edge. Same-cycle sb_set rd=7 with LSU clear of 7 → stays busy. Second sb_set rd=7 while busy → sb_err=1 until reset.
- With BYPASS_EN, EXU writes rd=3 data=0xABCD and rs2=3 → the cycle wb_wen=1 shows byp_rs2_hit=1, byp_rs2_data=0xABCD. With rs2=0 → hit=0. With the macro undefined → hit stays 0.
